sync_fifo_core: RTL

SYNC_FIFO_CORE -- requirements
Module: sync_fifo_core

---
 rtl/sync_fifo_core.sv | 115 +++++++++++
 1 files changed

// File: rtl/sync_fifo_core.sv
// Synchronous first-word-fall-through FIFO with level flags and sticky errors.
// Ports:
//   clk_in, n_rst        : clock, asynchronous active-low reset
//   wr_en, wr_data       : push one word per cycle when not full
//   rd_en, rd_data       : pop head word; rd_data shows head while not empty
//   flush                : synchronous discard of all contents
//   err_clr              : synchronous clear of overflow/underflow
//   full, empty          : count == DEPTH / count == 0
//   almost_full/_empty   : count >= AF_LEVEL / count <= AE_LEVEL
//   count                : stored words, 0..DEPTH
//   overflow, underflow  : sticky rejected-request flags
module sync_fifo_core #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned ADDR_BITS = 4,
   parameter int unsigned AF_LEVEL  = 14,
   parameter int unsigned AE_LEVEL  = 2
) (
   input  logic                 clk_in,
   input  logic                 n_rst,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   input  logic                 flush,
   input  logic                 err_clr,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [ADDR_BITS:0]   count,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;
   localparam int unsigned CNT_W = ADDR_BITS + 1;

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;
   logic                 wr_acc_c, rd_acc_c;
   logic                 ovf_set_c, unf_set_c;

   // Status decodes come from the count register only
   assign full         = (count_q == CNT_W'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
   assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Head word falls through; forced to zero when nothing is stored
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // Acceptance, next-state pointers, count and sticky flags
   always_comb begin
      wr_acc_c    = 1'b0;
      rd_acc_c    = 1'b0;
      ovf_set_c   = 1'b0;
      unf_set_c   = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      if (flush) begin
         // Flush overrides requests and raises no errors
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_acc_c  = wr_en & ~full;
         rd_acc_c  = rd_en & ~empty;
         ovf_set_c = wr_en & full;
         unf_set_c = rd_en & empty;
         if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
         if (rd_acc_c) rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
         case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end

      // A new error in the clearing cycle keeps the flag set
      overflow_d  = (overflow_q  & ~err_clr) | ovf_set_c;
      underflow_d = (underflow_q & ~err_clr) | unf_set_c;
   end

   // Control state register
   always_ff @(posedge clk_in or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; contents are don't-care while empty, so no reset
   always_ff @(posedge clk_in) begin
      if (wr_acc_c) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule
